// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32 control FSM for variable-latency memories: ready/valid memory
// handshake with bounded wait, trap and debug-halt states, retired-instruction counter.
package mc_ctrl_pkg;
    typedef enum logic {ADDR_PC = 1'b0, ADDR_RESULT = 1'b1} mem_addr_sel_t;
    typedef enum logic [1:0] {RS1V = 2'd0, PC_OLD = 2'd1, PC = 2'd2} alu_src1_sel_t;
    typedef enum logic [1:0] {RS2V = 2'd0, IMM = 2'd1, PC_INC = 2'd2} alu_src2_sel_t;
    typedef enum logic [1:0] {ALU_CLOCKED = 2'd0, ALU_RESULT = 2'd1, MEM_RD = 2'd2} result_sel_t;
    typedef enum logic [1:0] {ADD_OP = 2'd0, SUB_OP = 2'd1, FUNCT_DEFINED = 2'd2} alu_ops_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_STYPE = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_BTYPE = 7'b1100011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
endpackage

module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned RETIRE_W    = 32,
    parameter bit          HALT_EN     = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                mem_ready,
    input  logic                halt_req,
    output logic                mem_req,
    output logic                branch,
    output logic                reg_wren,
    output logic                mem_wren,
    output logic                pc_update,
    output logic                inst_en,
    output mem_addr_sel_t       mem_addr_sel,
    output alu_src1_sel_t       alu_src1_sel,
    output alu_src2_sel_t       alu_src2_sel,
    output result_sel_t         result_sel,
    output alu_ops_t            alu_op,
    output logic [2:0]          branch_funct3,
    output logic                halted,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [RETIRE_W-1:0] instret
);
    localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_BOOT, S_FETCH, S_DECODE, S_MEM_ADDR, S_EXEC_R, S_EXEC_I, S_MEM_READ,
        S_MEM_WRITE, S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_HALT, S_TRAP
    } state_t;

    typedef struct packed {
        logic          mem_req;
        logic          branch;
        logic          reg_wren;
        logic          mem_wren;
        logic          fetch;
        logic          jump;
        logic          halted;
        logic          trap;
        mem_addr_sel_t mas;
        alu_src1_sel_t src1;
        alu_src2_sel_t src2;
        result_sel_t   res;
        alu_ops_t      op;
    } ctrl_t;

    // Control word for the state being entered; registering it keeps outputs glitch-free.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c.mem_req  = 1'b0;
        c.branch   = 1'b0;
        c.reg_wren = 1'b0;
        c.mem_wren = 1'b0;
        c.fetch    = 1'b0;
        c.jump     = 1'b0;
        c.halted   = 1'b0;
        c.trap     = 1'b0;
        c.mas      = ADDR_PC;
        c.src1     = RS1V;
        c.src2     = RS2V;
        c.res      = ALU_CLOCKED;
        c.op       = ADD_OP;
        case (s)
            S_FETCH:     begin c.mem_req = 1'b1; c.fetch = 1'b1; c.src1 = PC;
                               c.src2 = PC_INC; c.res = ALU_RESULT; end
            S_DECODE:    begin c.src1 = PC_OLD; c.src2 = IMM; end
            S_MEM_ADDR:  c.src2 = IMM;
            S_EXEC_R:    c.op = FUNCT_DEFINED;
            S_EXEC_I:    begin c.src2 = IMM; c.op = FUNCT_DEFINED; end
            S_MEM_READ:  begin c.mem_req = 1'b1; c.mas = ADDR_RESULT; end
            S_MEM_WRITE: begin c.mem_req = 1'b1; c.mem_wren = 1'b1; c.mas = ADDR_RESULT; end
            S_MEM_WB:    begin c.reg_wren = 1'b1; c.res = MEM_RD; end
            S_ALU_WB:    c.reg_wren = 1'b1;
            S_BRANCH:    begin c.branch = 1'b1; c.op = SUB_OP; end
            S_JUMP:      begin c.jump = 1'b1; c.src1 = PC_OLD; c.src2 = PC_INC; end
            S_HALT:      c.halted = 1'b1;
            S_TRAP:      c.trap = 1'b1;
            default:     ;
        endcase
        return c;
    endfunction

    state_t              state_q, state_d, boundary_s;
    ctrl_t               ctrl_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          cause_q, cause_d;
    logic [2:0]          f3_q;
    logic [RETIRE_W-1:0] instret_q;
    logic                retire, mem_wait;

    assign boundary_s = (HALT_EN && halt_req) ? S_HALT : S_FETCH;

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        cnt_d    = cnt_q;
        retire   = 1'b0;
        mem_wait = 1'b0;
        case (state_q)
            S_BOOT:      state_d = boundary_s;
            S_FETCH:     if (mem_ready) state_d = S_DECODE; else mem_wait = 1'b1;
            S_DECODE: begin
                case (opcode)
                    OPC_RTYPE:                      state_d = S_EXEC_R;
                    OPC_ITYPE, OPC_LUI, OPC_AUIPC:  state_d = S_EXEC_I;
                    OPC_LOAD, OPC_STYPE:            state_d = S_MEM_ADDR;
                    OPC_BTYPE:                      state_d = S_BRANCH;
                    OPC_JAL, OPC_JALR:              state_d = S_JUMP;
                    default: begin state_d = S_TRAP; cause_d = 2'b01; end
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OPC_STYPE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB; else mem_wait = 1'b1;
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    state_d = boundary_s;
                    retire  = 1'b1;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            S_EXEC_R, S_EXEC_I, S_JUMP:   state_d = S_ALU_WB;
            S_ALU_WB, S_MEM_WB, S_BRANCH: begin state_d = boundary_s; retire = 1'b1; end
            S_HALT:      if (!halt_req) state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_BOOT;
        endcase
        // Ready in the threshold cycle never reaches here, so ready wins over timeout.
        if (mem_wait) begin
            if (MEM_TIMEOUT != 0 && cnt_q == TMO_LAST) begin
                state_d = S_TRAP;
                cause_d = 2'b10;
            end
            cnt_d = cnt_q + 1'b1;
        end
        if (state_d != state_q) cnt_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_BOOT;
            ctrl_q    <= ctrl_for(S_BOOT);
            cnt_q     <= '0;
            cause_q   <= 2'b00;
            f3_q      <= 3'b000;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for(state_d);
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            if (state_q == S_DECODE) f3_q <= funct3;
            if (retire) instret_q <= instret_q + 1'b1;
        end
    end

    assign mem_req       = ctrl_q.mem_req;
    assign branch        = ctrl_q.branch;
    assign reg_wren      = ctrl_q.reg_wren;
    assign mem_wren      = ctrl_q.mem_wren;
    assign inst_en       = ctrl_q.fetch & mem_ready;
    assign pc_update     = (ctrl_q.fetch & mem_ready) | ctrl_q.jump;
    assign mem_addr_sel  = ctrl_q.mas;
    // JALR adds the immediate to rs1; the opcode is only valid once DECODE has begun.
    assign alu_src1_sel  = (state_q == S_DECODE && opcode == OPC_JALR) ? RS1V : ctrl_q.src1;
    assign alu_src2_sel  = ctrl_q.src2;
    assign result_sel    = ctrl_q.res;
    assign alu_op        = ctrl_q.op;
    assign branch_funct3 = f3_q;
    assign halted        = ctrl_q.halted;
    assign trap          = ctrl_q.trap;
    assign trap_cause    = cause_q;
    assign instret       = instret_q;
endmodule
